// File: rtl/alu_pkg.sv
// Shared op codes, FSM state encoding and op-class helper for the iterative ALU.
// Pure declarations: no logic, no latency, no flow control of its own.
package alu_pkg;

   localparam logic [4:0] OP_AND   = 5'b00000;
   localparam logic [4:0] OP_OR    = 5'b00001;
   localparam logic [4:0] OP_ADD   = 5'b00010;
   localparam logic [4:0] OP_SLL   = 5'b00100;
   localparam logic [4:0] OP_SRA   = 5'b00101;
   localparam logic [4:0] OP_SUB   = 5'b00110;
   localparam logic [4:0] OP_SLT   = 5'b00111;
   localparam logic [4:0] OP_SRL   = 5'b01000;
   localparam logic [4:0] OP_LUI   = 5'b01001;
   localparam logic [4:0] OP_SLTU  = 5'b01011;
   localparam logic [4:0] OP_NOR   = 5'b01100;
   localparam logic [4:0] OP_XOR   = 5'b01101;
   localparam logic [4:0] OP_MULT  = 5'b10000;
   localparam logic [4:0] OP_MULTU = 5'b10001;
   localparam logic [4:0] OP_DIV   = 5'b10010;
   localparam logic [4:0] OP_DIVU  = 5'b10011;
   localparam logic [4:0] OP_MFHI  = 5'b10100;
   localparam logic [4:0] OP_MFLO  = 5'b10101;
   localparam logic [4:0] OP_MTHI  = 5'b10110;
   localparam logic [4:0] OP_MTLO  = 5'b10111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_FIX  = 2'd3
   } state_e;

   // MULT/MULTU/DIV/DIVU: op[1] selects divide, op[0] selects unsigned.
   function automatic logic is_muldiv(input logic [4:0] op);
      return op[4:2] == 3'b100;
   endfunction

endpackage

// File: rtl/muldiv_core.sv
// Radix-2 shift-add multiplier / restoring divider with sign fix-up; WIDTH iterations + FIX cycle
// (divide-by-zero skips straight to FIX). Accepts start only when idle; flush aborts any cycle.
module muldiv_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             start,
   input  logic             is_div,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             dz
);
   localparam int CW = $clog2(WIDTH);

   state_e             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] p_q, p_d;
   logic [WIDTH-1:0]   m_q, m_d;
   logic               div_q, div_d, neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d;

   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     mul_sum, div_sh, div_diff;
   logic [2*WIDTH-1:0] prod;

   // p holds {acc, multiplier} when multiplying and {remainder, dividend/quotient} when dividing.
   always_comb begin
      a_mag    = (is_signed && a[WIDTH-1]) ? -a : a;
      b_mag    = (is_signed && b[WIDTH-1]) ? -b : b;
      mul_sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, m_q} : '0);
      div_sh   = p_q[2*WIDTH-1:WIDTH-1];
      div_diff = div_sh - {1'b0, m_q};

      state_d = state_q;
      cnt_d   = cnt_q;
      p_d     = p_q;
      m_d     = m_q;
      div_d   = div_q;
      neg_d   = neg_q;
      rneg_d  = rneg_q;
      dz_d    = dz_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               div_d  = is_div;
               neg_d  = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
               rneg_d = is_signed && a[WIDTH-1];
               dz_d   = is_div && (b == '0);
               cnt_d  = CW'(WIDTH - 1);
               if (is_div && (b == '0)) begin
                  p_d     = {a, {WIDTH{1'b1}}};
                  state_d = ST_FIX;
               end else if (is_div) begin
                  p_d     = {{WIDTH{1'b0}}, a_mag};
                  m_d     = b_mag;
                  state_d = ST_DIV;
               end else begin
                  p_d     = {{WIDTH{1'b0}}, b_mag};
                  m_d     = a_mag;
                  state_d = ST_MUL;
               end
            end
         end
         ST_MUL: p_d = {mul_sum, p_q[WIDTH-1:1]};
         ST_DIV: p_d = div_diff[WIDTH] ? {div_sh[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0}
                                       : {div_diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
         default: state_d = ST_IDLE;
      endcase

      if (state_q == ST_MUL || state_q == ST_DIV) begin
         cnt_d = cnt_q - CW'(1);
         if (cnt_q == '0) state_d = ST_FIX;
      end
      if (flush) state_d = ST_IDLE;
   end

   always_comb begin
      prod = neg_q ? -p_q : p_q;
      hi   = prod[2*WIDTH-1:WIDTH];
      lo   = prod[WIDTH-1:0];
      if (dz_q) begin
         hi = p_q[2*WIDTH-1:WIDTH];
         lo = p_q[WIDTH-1:0];
      end else if (div_q) begin
         lo = neg_q  ? -p_q[WIDTH-1:0]       : p_q[WIDTH-1:0];
         hi = rneg_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];
      end
   end

   assign busy = (state_q != ST_IDLE);
   assign done = (state_q == ST_FIX) && !flush;
   assign dz   = dz_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         p_q     <= '0;
         m_q     <= '0;
         div_q   <= 1'b0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         p_q     <= p_d;
         m_q     <= m_d;
         div_q   <= div_d;
         neg_q   <= neg_d;
         rneg_q  <= rneg_d;
         dz_q    <= dz_d;
      end
   end

endmodule

// File: rtl/iter_alu.sv
// Execute-stage ALU: single-cycle ops and MF/MT in 1 cycle, MULT/DIV in WIDTH+2 (div-by-zero in 2).
// in_ready drops while an iterative op is in flight; flush aborts the accepted/in-flight op.
module iter_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic [SHW-1:0]   shamt,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_result,
   output logic             busy,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);
   logic             accept, md_start, single;
   logic             core_busy, core_done, core_dz;
   logic [WIDTH-1:0] core_hi, core_lo, alu_res;
   logic             out_valid_q, out_valid_d, div_zero_q, div_zero_d;
   logic [WIDTH-1:0] out_result_q, out_result_d, hi_q, hi_d, lo_q, lo_d;

   muldiv_core #(.WIDTH(WIDTH)) u_muldiv (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .start     (md_start),
      .is_div    (op[1]),
      .is_signed (!op[0]),
      .a         (src_a),
      .b         (src_b),
      .busy      (core_busy),
      .done      (core_done),
      .hi        (core_hi),
      .lo        (core_lo),
      .dz        (core_dz)
   );

   assign in_ready = !core_busy;

   always_comb begin
      accept   = in_valid && in_ready && !flush;
      md_start = accept && is_muldiv(op);
      single   = accept && !is_muldiv(op);

      alu_res = '0;
      case (op)
         OP_ADD:  alu_res = src_a + src_b;
         OP_SUB:  alu_res = src_a - src_b;
         OP_AND:  alu_res = src_a & src_b;
         OP_OR:   alu_res = src_a | src_b;
         OP_NOR:  alu_res = ~(src_a | src_b);
         OP_XOR:  alu_res = src_a ^ src_b;
         OP_SLL:  alu_res = src_b << shamt;
         OP_SRL:  alu_res = src_b >> shamt;
         OP_SRA:  alu_res = $signed(src_b) >>> shamt;
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
         OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, src_a < src_b};
         OP_LUI:  alu_res = {src_b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
         OP_MFHI: alu_res = hi_q;
         OP_MFLO: alu_res = lo_q;
         OP_MTHI: alu_res = src_a;
         OP_MTLO: alu_res = src_a;
         default: alu_res = '0;
      endcase

      // core_done only occurs in FIX, when no new op can be accepted, so the two never collide.
      out_valid_d  = single || core_done;
      div_zero_d   = core_done && core_dz;
      out_result_d = out_result_q;
      hi_d         = hi_q;
      lo_d         = lo_q;
      if (core_done) begin
         out_result_d = core_lo;
         hi_d         = core_hi;
         lo_d         = core_lo;
      end else if (single) begin
         out_result_d = alu_res;
         if (op == OP_MTHI) hi_d = src_a;
         if (op == OP_MTLO) lo_d = src_a;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         out_result_q <= '0;
         div_zero_q   <= 1'b0;
         hi_q         <= '0;
         lo_q         <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_result_q <= out_result_d;
         div_zero_q   <= div_zero_d;
         hi_q         <= hi_d;
         lo_q         <= lo_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_result = out_result_q;
   assign div_zero   = div_zero_q;
   assign hi_o       = hi_q;
   assign lo_o       = lo_q;
   assign busy       = core_busy;

endmodule

// File: tb/tb_iter_alu.sv
// Scoreboarded random + directed bench for iter_alu (WIDTH=32) plus a WIDTH=16 multiply spot check.
module tb_iter_alu;
   import alu_pkg::*;

   localparam int W = 32;

   logic        clk = 1'b0;
   logic        rst_n, flush, in_valid, in_ready, out_valid, busy, div_zero;
   logic [4:0]  op, shamt;
   logic [31:0] src_a, src_b, out_result, hi_o, lo_o;

   logic        in_valid16, in_ready16, out_valid16, busy16, div_zero16;
   logic [4:0]  op16;
   logic [3:0]  shamt16;
   logic [15:0] src_a16, src_b16, out_result16, hi16, lo16;

   int cyc = 0;
   int n_pass = 0;
   int n_total = 0;

   typedef struct {
      logic [31:0] res;
      logic        dz;
      logic [31:0] hi;
      logic [31:0] lo;
      int          due;
   } exp_t;

   exp_t        sbq[$];
   exp_t        mon_e;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   logic [4:0] pool [26] = '{OP_AND, OP_OR, OP_ADD, OP_SLL, OP_SRA, OP_SUB, OP_SLT, OP_SRL,
                             OP_LUI, OP_SLTU, OP_NOR, OP_XOR, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
                             OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO, 5'b00011, 5'b01010, 5'b01110,
                             5'b01111, 5'b11000, 5'b11111};

   iter_alu #(.WIDTH(32)) u_dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .src_a(src_a), .src_b(src_b), .shamt(shamt), .out_valid(out_valid),
      .out_result(out_result), .busy(busy), .div_zero(div_zero), .hi_o(hi_o), .lo_o(lo_o)
   );

   iter_alu #(.WIDTH(16)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .flush(1'b0), .in_valid(in_valid16), .in_ready(in_ready16),
      .op(op16), .src_a(src_a16), .src_b(src_b16), .shamt(shamt16), .out_valid(out_valid16),
      .out_result(out_result16), .busy(busy16), .div_zero(div_zero16), .hi_o(hi16), .lo_o(lo16)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
   endtask

   // Reference model: plain integer arithmetic on the architectural HI/LO state.
   task automatic model(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh);
      exp_t        e;
      longint      sp, sq, sr;
      logic [63:0] up;
      e.res = '0;
      e.dz  = 1'b0;
      e.due = cyc + 1;
      case (o)
         OP_ADD:  e.res = a + b;
         OP_SUB:  e.res = a - b;
         OP_AND:  e.res = a & b;
         OP_OR:   e.res = a | b;
         OP_NOR:  e.res = ~(a | b);
         OP_XOR:  e.res = a ^ b;
         OP_SLL:  e.res = b << sh;
         OP_SRL:  e.res = b >> sh;
         OP_SRA:  e.res = $signed(b) >>> sh;
         OP_SLT:  e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         OP_SLTU: e.res = (a < b) ? 32'd1 : 32'd0;
         OP_LUI:  e.res = b * 32'h10000;
         OP_MFHI: e.res = m_hi;
         OP_MFLO: e.res = m_lo;
         OP_MTHI: begin e.res = a; m_hi = a; end
         OP_MTLO: begin e.res = a; m_lo = a; end
         OP_MULT: begin
            sp = longint'($signed(a)) * longint'($signed(b));
            m_hi = sp[63:32]; m_lo = sp[31:0]; e.due = cyc + W + 2;
         end
         OP_MULTU: begin
            up = {32'd0, a} * {32'd0, b};
            m_hi = up[63:32]; m_lo = up[31:0]; e.due = cyc + W + 2;
         end
         OP_DIV, OP_DIVU: begin
            if (b == 0) begin
               m_hi = a; m_lo = 32'hFFFF_FFFF; e.dz = 1'b1; e.due = cyc + 2;
            end else if (o == OP_DIV) begin
               sq = longint'($signed(a)) / longint'($signed(b));
               sr = longint'($signed(a)) % longint'($signed(b));
               m_lo = sq[31:0]; m_hi = sr[31:0]; e.due = cyc + W + 2;
            end else begin
               m_lo = a / b; m_hi = a % b; e.due = cyc + W + 2;
            end
         end
         default: e.res = '0;
      endcase
      if (is_muldiv(o)) e.res = m_lo;
      e.hi = m_hi;
      e.lo = m_lo;
      sbq.push_back(e);
   endtask

   // Called at a negedge; presents the op for one cycle once in_ready is high.
   task automatic issue(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input bit expect_it);
      int guard = 0;
      while (!in_ready && guard < 100) begin @(negedge clk); guard++; end
      if (!in_ready) chk("in_ready_wait", 64'(in_ready), 64'd1);
      op = o; src_a = a; src_b = b; shamt = sh; in_valid = 1'b1;
      if (expect_it && !flush) model(o, a, b, sh);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (sbq.size() == 0) chk("unexpected_out_valid", 64'(out_valid), 64'd0);
         else begin
            mon_e = sbq.pop_front();
            chk("result", 64'(out_result), 64'(mon_e.res));
            chk("div_zero", 64'(div_zero), 64'(mon_e.dz));
            chk("hi", 64'(hi_o), 64'(mon_e.hi));
            chk("lo", 64'(lo_o), 64'(mon_e.lo));
            chk("latency", 64'(cyc), 64'(mon_e.due));
         end
      end
   end

   initial begin
      int          n;
      int          lat;
      logic [4:0]  o;
      logic [31:0] a, b;

      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; op = '0; src_a = '0; src_b = '0; shamt = '0;
      in_valid16 = 1'b0; op16 = '0; src_a16 = '0; src_b16 = '0; shamt16 = '0;
      repeat (3) @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_result", 64'(out_result), 64'd0);
      chk("rst_hi", 64'(hi_o), 64'd0);
      chk("rst_lo", 64'(lo_o), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_div_zero", 64'(div_zero), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'd1);

      issue(OP_ADD, 32'h7FFF_FFFF, 32'd1, 5'd0, 1'b1);
      issue(OP_SRA, 32'd0, 32'h8000_0000, 5'd4, 1'b1);
      issue(OP_SLTU, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b1);
      issue(OP_LUI, 32'd0, 32'h0000_ABCD, 5'd0, 1'b1);
      issue(OP_MULT, 32'hFFFF_FFFD, 32'd7, 5'd0, 1'b1);
      n = 0;
      while (!in_ready && n < 100) begin n++; @(negedge clk); end
      chk("mult_stall_cycles", 64'(n), 64'd33);
      issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd0, 1'b1);
      issue(OP_DIVU, 32'd100, 32'd7, 5'd0, 1'b1);
      issue(OP_MFHI, 32'd0, 32'd0, 5'd0, 1'b1);
      issue(OP_DIVU, 32'd5, 32'd0, 5'd0, 1'b1);
      issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 1'b1);
      issue(OP_MTHI, 32'h1234, 32'd0, 5'd0, 1'b1);
      issue(OP_MFHI, 32'd0, 32'd0, 5'd0, 1'b1);
      issue(OP_MTLO, 32'h5678, 32'd0, 5'd0, 1'b1);
      issue(OP_MFLO, 32'd0, 32'd0, 5'd0, 1'b1);

      // A flushed MT* must not touch HI.
      flush = 1'b1;
      issue(OP_MTHI, 32'hDEAD, 32'd0, 5'd0, 1'b0);
      flush = 1'b0;
      issue(OP_MFHI, 32'd0, 32'd0, 5'd0, 1'b1);

      // Abort a MULTU around iteration 10.
      issue(OP_MULTU, 32'hFFFF_0001, 32'h1234_5678, 5'd0, 1'b0);
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_in_ready", 64'(in_ready), 64'd1);
      chk("flush_busy", 64'(busy), 64'd0);
      chk("flush_hi", 64'(hi_o), 64'(m_hi));
      chk("flush_lo", 64'(lo_o), 64'(m_lo));
      issue(OP_SUB, 32'd3, 32'd5, 5'd0, 1'b1);

      // Reset in the middle of a divide.
      issue(OP_DIV, 32'd1000, 32'd3, 5'd0, 1'b0);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      chk("midrst_out_result", 64'(out_result), 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_hi", 64'(hi_o), 64'd0);
      chk("midrst_lo", 64'(lo_o), 64'd0);
      chk("midrst_div_zero", 64'(div_zero), 64'd0);
      sbq.delete();
      m_hi = '0; m_lo = '0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      repeat (150) begin
         o = pool[$urandom_range(0, 25)];
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 7))
            0: b = '0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: b = $urandom_range(1, 1000);
            3: a = $urandom_range(0, 50000);
            default: ;
         endcase
         issue(o, a, b, 5'($urandom_range(0, 31)), 1'b1);
         if ($urandom_range(0, 3) == 0) @(negedge clk);
      end

      n = 0;
      while (sbq.size() != 0 && n < 200) begin n++; @(negedge clk); end
      chk("drain", 64'(sbq.size()), 64'd0);

      // WIDTH=16 instance: MULT -3 x 7.
      op16 = OP_MULT; src_a16 = 16'hFFFD; src_b16 = 16'd7; in_valid16 = 1'b1;
      lat = cyc;
      @(negedge clk);
      in_valid16 = 1'b0;
      n = 0;
      while (!out_valid16 && n < 60) begin n++; @(negedge clk); end
      chk("w16_latency", 64'(out_valid16 ? cyc - lat : -1), 64'd18);
      chk("w16_result", 64'(out_result16), 64'hFFEB);
      chk("w16_hi", 64'(hi16), 64'hFFFF);
      chk("w16_lo", 64'(lo16), 64'hFFEB);

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
